// File: rtl/patch_stream_scheduler_pkg.sv
// Shared types for the patch stream scheduler.
//   patch_state_t : controller state encoding (also driven on the state port)
//   patch_beat_t  : one stream beat (pixel plus patch/position tags and flags)
// The beat struct is sized for the default frame geometry. Smaller geometries
// zero-extend into it and truncate back out at the stream interface.
package patch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DONE   = 2'b10
    } patch_state_t;

    // Index width for a counter with n distinct values (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_CHANNEL_SIZE = 8;
    localparam int unsigned DEF_NUM_CHANNELS = 3;
    localparam int unsigned DEF_IMG_WIDTH    = 64;
    localparam int unsigned DEF_IMG_HEIGHT   = 64;
    localparam int unsigned DEF_PATCH_SIZE   = 16;

    localparam int unsigned BEAT_PIXEL_W     = DEF_CHANNEL_SIZE * DEF_NUM_CHANNELS;
    localparam int unsigned BEAT_PATCH_IDX_W =
        idx_w((DEF_IMG_WIDTH / DEF_PATCH_SIZE) * (DEF_IMG_HEIGHT / DEF_PATCH_SIZE));
    localparam int unsigned BEAT_POS_IDX_W   = idx_w(DEF_PATCH_SIZE * DEF_PATCH_SIZE);

    typedef struct packed {
        logic [BEAT_PIXEL_W-1:0]     pixel;
        logic [BEAT_PATCH_IDX_W-1:0] patch_index;
        logic [BEAT_POS_IDX_W-1:0]   position_index;
        logic                        last_in_patch;
        logic                        last;
    } patch_beat_t;

endpackage

// File: rtl/patch_stream_scheduler_if.sv
// Valid/ready pixel stream from the scheduler to the patch-embedding datapath.
//   master : scheduler side (drives valid, pixel, tags, flags; samples ready)
//   slave  : consumer side (samples valid, pixel, tags, flags; drives ready)
interface patch_stream_scheduler_if
    import patch_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = BEAT_PIXEL_W,
    parameter int unsigned PATCH_IDX_W = BEAT_PATCH_IDX_W,
    parameter int unsigned POS_IDX_W   = BEAT_POS_IDX_W
);
    logic                   out_valid;
    logic                   out_ready;
    logic [PIXEL_WIDTH-1:0] out_pixel;
    logic [PATCH_IDX_W-1:0] out_patch_index;
    logic [POS_IDX_W-1:0]   out_position_index;
    logic                   out_last_in_patch;
    logic                   out_last;

    modport master (
        output out_valid, out_pixel, out_patch_index, out_position_index,
               out_last_in_patch, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pixel, out_patch_index, out_position_index,
               out_last_in_patch, out_last,
        output out_ready
    );
endinterface

// File: rtl/patch_stream_scheduler_fifo.sv
// patch_beat_fifo: 2-entry fall-through FIFO of stream beats.
//   clk, reset      : clock, async active-low reset
//   push, push_beat : write request and beat (beat arriving this cycle)
//   pop             : consumer took the head this cycle
//   head_valid/beat : current head; an arriving beat is visible at once when empty
//   count           : stored entries (0..2), excluding the arriving beat
module patch_beat_fifo
    import patch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  patch_beat_t push_beat,
    input  logic        pop,
    output logic        head_valid,
    output patch_beat_t head_beat,
    output logic [1:0]  count
);
    patch_beat_t mem_q [2];
    patch_beat_t mem_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        wr;
    logic        rd;

    // A beat popped in the same cycle it arrives into an empty FIFO is never stored.
    assign wr = push && !((count_q == 2'd0) && pop);
    assign rd = pop && (count_q != 2'd0);

    assign head_valid = (count_q != 2'd0) || push;
    assign head_beat  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : push_beat;
    assign count      = count_q;

    // Pointer, storage and occupancy update
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (wr) begin
            mem_d[wr_ptr_q] = push_beat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rd) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(wr) - 2'(rd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/patch_stream_scheduler.sv
// Patch stream scheduler: walks the image buffer in patch order through a
// 1-cycle-latency read port and streams one tagged pixel per beat.
//   clk, reset          : clock, async active-low reset
//   en                  : start request (IDLE only)
//   output_taken        : consumer acknowledge (DONE only)
//   state               : 00 IDLE, 01 STREAM, 10 DONE
//   rd_en/rd_row/rd_col : image buffer read request (address valid with rd_en)
//   rd_data             : pixel returned one cycle after rd_en
//   strm                : valid/ready beat stream (pixel, patch/position tags, flags)
module patch_stream_scheduler
    import patch_pkg::*;
#(
    parameter  int unsigned CHANNEL_SIZE = DEF_CHANNEL_SIZE,
    parameter  int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter  int unsigned IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter  int unsigned IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter  int unsigned PATCH_SIZE   = DEF_PATCH_SIZE,
    localparam int unsigned PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS,
    localparam int unsigned ROW_W        = idx_w(IMG_HEIGHT),
    localparam int unsigned COL_W        = idx_w(IMG_WIDTH)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   output_taken,
    output logic [1:0]             state,
    output logic                   rd_en,
    output logic [ROW_W-1:0]       rd_row,
    output logic [COL_W-1:0]       rd_col,
    input  logic [PIXEL_WIDTH-1:0] rd_data,
    patch_stream_scheduler_if.master strm
);
    localparam int unsigned PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE;
    localparam int unsigned TOTAL_NUM_PATCHES = PATCHES_IN_ROW * (IMG_HEIGHT / PATCH_SIZE);
    localparam int unsigned PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;
    localparam int unsigned PATCH_IDX_W       = idx_w(TOTAL_NUM_PATCHES);
    localparam int unsigned POS_IDX_W         = idx_w(PATCH_VECTOR_SIZE);
    localparam int unsigned PS_W              = idx_w(PATCH_SIZE);

    patch_state_t state_q, state_d;

    logic [PS_W-1:0]        pos_col_q, pos_col_d;
    logic [PS_W-1:0]        pos_row_q, pos_row_d;
    logic [COL_W-1:0]       col_base_q, col_base_d;
    logic [ROW_W-1:0]       row_base_q, row_base_d;
    logic [PATCH_IDX_W-1:0] patch_idx_q, patch_idx_d;
    logic [POS_IDX_W-1:0]   pos_idx_q, pos_idx_d;
    logic                   all_issued_q, all_issued_d;
    logic                   inflight_q;
    patch_beat_t            tag_q, tag_d;

    logic        pos_col_end, pos_row_end, col_base_end, row_base_end;
    logic        patch_end, frame_end;
    logic        pop;
    logic [2:0]  occupancy;

    patch_beat_t push_beat;
    patch_beat_t head_beat;
    logic        head_valid;
    logic [1:0]  fifo_count;

    // Wrap points of the nested address counters
    assign pos_col_end  = (pos_col_q  == PS_W'(PATCH_SIZE - 1));
    assign pos_row_end  = (pos_row_q  == PS_W'(PATCH_SIZE - 1));
    assign col_base_end = (col_base_q == COL_W'(IMG_WIDTH - PATCH_SIZE));
    assign row_base_end = (row_base_q == ROW_W'(IMG_HEIGHT - PATCH_SIZE));
    assign patch_end    = pos_col_end && pos_row_end;
    assign frame_end    = patch_end && col_base_end && row_base_end;

    assign rd_row = row_base_q + ROW_W'(pos_row_q);
    assign rd_col = col_base_q + COL_W'(pos_col_q);

    assign pop = head_valid && strm.out_ready;

    // Stored beats plus the one in flight, after this cycle's pop
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)                    state_d = STREAM;
            STREAM:  if (pop && head_beat.last) state_d = DONE;
            DONE:    if (output_taken)          state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // FSM outputs: issue a read only if its data is guaranteed a FIFO slot
    always_comb begin
        rd_en = 1'b0;
        if ((state_q == STREAM) && !all_issued_q && (occupancy < 3'd2)) begin
            rd_en = 1'b1;
        end
    end

    assign state = state_q;

    // Address walk and tag capture; tags ride one cycle behind rd_en with the data
    always_comb begin
        pos_col_d    = pos_col_q;
        pos_row_d    = pos_row_q;
        col_base_d   = col_base_q;
        row_base_d   = row_base_q;
        patch_idx_d  = patch_idx_q;
        pos_idx_d    = pos_idx_q;
        all_issued_d = all_issued_q;
        tag_d        = tag_q;

        if (state_q == IDLE) begin
            pos_col_d    = '0;
            pos_row_d    = '0;
            col_base_d   = '0;
            row_base_d   = '0;
            patch_idx_d  = '0;
            pos_idx_d    = '0;
            all_issued_d = 1'b0;
        end else if (rd_en) begin
            tag_d.pixel          = '0;
            tag_d.patch_index    = BEAT_PATCH_IDX_W'(patch_idx_q);
            tag_d.position_index = BEAT_POS_IDX_W'(pos_idx_q);
            tag_d.last_in_patch  = patch_end;
            tag_d.last           = frame_end;

            pos_col_d = pos_col_end ? '0 : pos_col_q + PS_W'(1);
            if (pos_col_end) begin
                pos_row_d = pos_row_end ? '0 : pos_row_q + PS_W'(1);
            end
            if (patch_end) begin
                col_base_d = col_base_end ? '0 : col_base_q + COL_W'(PATCH_SIZE);
            end
            if (patch_end && col_base_end) begin
                row_base_d = row_base_end ? '0 : row_base_q + ROW_W'(PATCH_SIZE);
            end
            pos_idx_d = patch_end ? '0 : pos_idx_q + POS_IDX_W'(1);
            if (patch_end) begin
                patch_idx_d = frame_end ? '0 : patch_idx_q + PATCH_IDX_W'(1);
            end
            if (frame_end) begin
                all_issued_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_col_q    <= '0;
            pos_row_q    <= '0;
            col_base_q   <= '0;
            row_base_q   <= '0;
            patch_idx_q  <= '0;
            pos_idx_q    <= '0;
            all_issued_q <= 1'b0;
            inflight_q   <= 1'b0;
            tag_q        <= '0;
        end else begin
            pos_col_q    <= pos_col_d;
            pos_row_q    <= pos_row_d;
            col_base_q   <= col_base_d;
            row_base_q   <= row_base_d;
            patch_idx_q  <= patch_idx_d;
            pos_idx_q    <= pos_idx_d;
            all_issued_q <= all_issued_d;
            inflight_q   <= rd_en;
            tag_q        <= tag_d;
        end
    end

    // Returning pixel joins its delayed tags
    always_comb begin
        push_beat       = tag_q;
        push_beat.pixel = BEAT_PIXEL_W'(rd_data);
    end

    patch_beat_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight_q),
        .push_beat  (push_beat),
        .pop        (pop),
        .head_valid (head_valid),
        .head_beat  (head_beat),
        .count      (fifo_count)
    );

    // Stream is the FIFO head; payload forced to zero whenever no beat is offered
    assign strm.out_valid          = head_valid;
    assign strm.out_pixel          = head_valid ? PIXEL_WIDTH'(head_beat.pixel) : '0;
    assign strm.out_patch_index    = head_valid ? PATCH_IDX_W'(head_beat.patch_index) : '0;
    assign strm.out_position_index = head_valid ? POS_IDX_W'(head_beat.position_index) : '0;
    assign strm.out_last_in_patch  = head_valid && head_beat.last_in_patch;
    assign strm.out_last           = head_valid && head_beat.last;
endmodule

// File: tb/tb_patch_stream_scheduler.sv
// Directed bench: a 4x4/2 instance and a default 64x64/16 instance share the
// clock; sel picks which one is driven and observed. Each image buffer returns
// {row,col} one cycle after rd_en.
module tb_patch_stream_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, output_taken, out_ready, sel;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  s_state, d_state;
    logic        s_rd_en, d_rd_en;
    logic [1:0]  s_rd_row, s_rd_col;
    logic [5:0]  d_rd_row, d_rd_col;
    logic [23:0] s_rd_data, d_rd_data;

    patch_stream_scheduler_if #(.PIXEL_WIDTH(24), .PATCH_IDX_W(2), .POS_IDX_W(2)) s_if ();
    patch_stream_scheduler_if #(.PIXEL_WIDTH(24), .PATCH_IDX_W(4), .POS_IDX_W(8)) d_if ();

    patch_stream_scheduler #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PATCH_SIZE(2)) u_small (
        .clk(clk), .reset(reset), .en(en & ~sel), .output_taken(output_taken & ~sel),
        .state(s_state), .rd_en(s_rd_en), .rd_row(s_rd_row), .rd_col(s_rd_col),
        .rd_data(s_rd_data), .strm(s_if.master)
    );

    patch_stream_scheduler u_dflt (
        .clk(clk), .reset(reset), .en(en & sel), .output_taken(output_taken & sel),
        .state(d_state), .rd_en(d_rd_en), .rd_row(d_rd_row), .rd_col(d_rd_col),
        .rd_data(d_rd_data), .strm(d_if.master)
    );

    assign s_if.out_ready = out_ready;
    assign d_if.out_ready = out_ready;

    always @(posedge clk) if (s_rd_en) s_rd_data <= 24'({s_rd_row, s_rd_col});
    always @(posedge clk) if (d_rd_en) d_rd_data <= 24'({d_rd_row, d_rd_col});

    logic [1:0]  m_state;
    logic        m_rd_en, m_valid, m_lip, m_last;
    logic [23:0] m_pixel;
    logic [7:0]  m_pidx, m_qidx;

    assign m_state = sel ? d_state : s_state;
    assign m_rd_en = sel ? d_rd_en : s_rd_en;
    assign m_valid = sel ? d_if.out_valid : s_if.out_valid;
    assign m_pixel = sel ? d_if.out_pixel : s_if.out_pixel;
    assign m_pidx  = sel ? 8'(d_if.out_patch_index)    : 8'(s_if.out_patch_index);
    assign m_qidx  = sel ? 8'(d_if.out_position_index) : 8'(s_if.out_position_index);
    assign m_lip   = sel ? d_if.out_last_in_patch : s_if.out_last_in_patch;
    assign m_last  = sel ? d_if.out_last : s_if.out_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse en; returns #1 after the edge that samples it (E0)
    task automatic start_frame();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("start_state", 32'(m_state), 32'd1);
    endtask

    task automatic pulse_ot(input logic [1:0] exp_state);
        @(negedge clk);
        output_taken = 1'b1;
        @(posedge clk);
        #1;
        output_taken = 1'b0;
        check("ot_state", 32'(m_state), 32'(exp_state));
    endtask

    // Consume one frame from cycle 0 after E0. ready_mode 0: always ready,
    // 1: random; ready held low for the first 'hold' cycles. abort_k >= 0
    // drops reset mid-cycle once that many beats were seen. pulse_c pulses
    // en and output_taken during that cycle.
    task automatic run_stream(input int ps, input int pir, input int cw, input int nb,
                              input int ready_mode, input int hold,
                              input int abort_k, input int pulse_c);
        int c, k, reads, pops, pvs, p, q, erow, ecol;
        logic stall;
        logic [23:0] pv_pixel;
        logic [7:0]  pv_pidx, pv_qidx;
        pvs = ps * ps; c = 0; k = 0; reads = 0; pops = 0; stall = 1'b0;
        pv_pixel = '0; pv_pidx = '0; pv_qidx = '0;
        while (k < nb && c < 4 * nb + 100) begin
            if (c < hold)           out_ready = 1'b0;
            else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else                    out_ready = 1'b1;
            if (c == pulse_c) begin en = 1'b1; output_taken = 1'b1; end
            @(negedge clk);
            if (c == 0) begin
                check("first_rd_en", 32'(m_rd_en), 32'd1);
                check("first_valid_low", 32'(m_valid), 32'd0);
            end
            if (c == 1) check("valid_after_e1", 32'(m_valid), 32'd1);
            if (stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_pixel", 32'(m_pixel), 32'(pv_pixel));
                check("stall_pidx", 32'(m_pidx), 32'(pv_pidx));
                check("stall_qidx", 32'(m_qidx), 32'(pv_qidx));
            end
            check("outstanding_le2",
                  32'((reads + int'(m_rd_en) - pops - int'(m_valid && out_ready)) <= 2), 32'd1);
            if (hold > 0 && c == hold - 1) begin
                check("hold_reads", 32'(reads + int'(m_rd_en)), 32'd2);
                check("hold_rd_en_low", 32'(m_rd_en), 32'd0);
            end
            stall = m_valid && !out_ready;
            pv_pixel = m_pixel; pv_pidx = m_pidx; pv_qidx = m_qidx;
            reads += int'(m_rd_en);
            if (m_valid && out_ready) begin
                p = k / pvs; q = k % pvs;
                erow = (p / pir) * ps + q / ps;
                ecol = (p % pir) * ps + q % ps;
                check("beat_pixel", 32'(m_pixel), 32'((erow << cw) | ecol));
                check("beat_pidx", 32'(m_pidx), 32'(p));
                check("beat_qidx", 32'(m_qidx), 32'(q));
                check("beat_lip", 32'(m_lip), 32'(q == pvs - 1));
                check("beat_last", 32'(m_last), 32'(k == nb - 1));
                pops++;
                k++;
                if (k == abort_k) begin
                    #2;
                    reset = 1'b0;
                    #1;
                    check("abort_state", 32'(m_state), 32'd0);
                    check("abort_valid", 32'(m_valid), 32'd0);
                    check("abort_rd_en", 32'(m_rd_en), 32'd0);
                    check("abort_pixel", 32'(m_pixel), 32'd0);
                    check("abort_tags", 32'({m_pidx, m_qidx, m_lip, m_last}), 32'd0);
                    return;
                end
            end
            @(posedge clk);
            #1;
            en = 1'b0;
            output_taken = 1'b0;
            c++;
            check("stream_state", 32'(m_state), (k == nb) ? 32'd2 : 32'd1);
        end
        check("all_beats", 32'(k), 32'(nb));
        if (ready_mode == 0 && hold == 0) check("done_edges", 32'(c), 32'(nb + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; en = 1'b0; output_taken = 1'b0; out_ready = 1'b1; sel = 1'b0;
        #12;
        check("reset_state", 32'(m_state), 32'd0);
        check("reset_valid", 32'(m_valid), 32'd0);
        check("reset_rd_en", 32'(m_rd_en), 32'd0);
        check("reset_pixel", 32'(m_pixel), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Small geometry: acknowledge in IDLE ignored, full frame, en in DONE ignored
        pulse_ot(2'd0);
        check("idle_no_read", 32'(m_rd_en), 32'd0);
        start_frame();
        run_stream(2, 2, 2, 16, 0, 0, -1, -1);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("done_ignores_en", 32'(m_state), 32'd2);
        check("done_valid_low", 32'(m_valid), 32'd0);
        pulse_ot(2'd0);

        // Default geometry, always ready, en/output_taken pulsed mid-stream
        sel = 1'b1;
        start_frame();
        run_stream(16, 4, 6, 4096, 0, 0, -1, 50);
        pulse_ot(2'd0);

        // Random backpressure
        start_frame();
        run_stream(16, 4, 6, 4096, 1, 0, -1, -1);
        pulse_ot(2'd0);

        // Asynchronous abort at beat 100, then restart with initial stall
        start_frame();
        run_stream(16, 4, 6, 4096, 0, 0, 100, -1);
        @(posedge clk);
        #1;
        check("abort_held_state", 32'(m_state), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        start_frame();
        run_stream(16, 4, 6, 4096, 0, 20, -1, -1);
        pulse_ot(2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
